// File: rtl/alu_uart_interface.sv
// rtl/alu_uart_interface.sv - sequences UART bytes into ALU operands/opcode and returns the result
// Optional inter-byte timeout: define ALU_UART_INTERFACE_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int WIDTH_WORD      = 8,
  parameter int BUS_DATOS_ALU   = 8,
  parameter int BUS_SALIDA_ALU  = 8,
  parameter int CANT_BIT_OPCODE = 8,
  parameter int TIMEOUT_CYCLES  = 10416000
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [WIDTH_WORD-1:0]      i_rx_data,
  input  logic                       i_rx_done,
  input  logic                       i_tx_done,
  input  logic [BUS_SALIDA_ALU-1:0]  i_resultado_alu,
  output logic [BUS_DATOS_ALU-1:0]   o_dato_A,
  output logic [BUS_DATOS_ALU-1:0]   o_dato_B,
  output logic [CANT_BIT_OPCODE-1:0] o_opcode,
  output logic [WIDTH_WORD-1:0]      o_tx_data,
  output logic                       o_tx_start,
  output logic                       o_busy
);

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    ESPERA_OP = 3'd2,
    ENVIO     = 3'd3,
    ESPERA_TX = 3'd4
  } state_t;

  state_t state, state_next;
  logic   ld_a, ld_b, ld_op, ld_tx;

`ifdef ALU_UART_INTERFACE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] timeout_cnt, timeout_cnt_next;
  logic             timeout_hit;

  assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts only while parked waiting for B or the opcode; any byte or state move restarts it.
  always_comb begin
    timeout_cnt_next = '0;
    if ((state == ESPERA_B || state == ESPERA_OP) && !i_rx_done && (state_next == state))
      timeout_cnt_next = timeout_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) timeout_cnt <= '0;
    else          timeout_cnt <= timeout_cnt_next;
  end
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ESPERA_A;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    ld_op = 1'b0;
    ld_tx = 1'b0;
    case (state)
      ESPERA_A: begin
        if (i_rx_done) begin
          ld_a       = 1'b1;
          state_next = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (i_rx_done) begin
          ld_b       = 1'b1;
          state_next = ESPERA_OP;
        end
`ifdef ALU_UART_INTERFACE_TIMEOUT_EN
        else if (timeout_hit) state_next = ESPERA_A;
`endif
      end
      ESPERA_OP: begin
        if (i_rx_done) begin
          ld_op      = 1'b1;
          state_next = ENVIO;
        end
`ifdef ALU_UART_INTERFACE_TIMEOUT_EN
        else if (timeout_hit) state_next = ESPERA_A;
`endif
      end
      ENVIO: begin
        ld_tx      = 1'b1;
        state_next = ESPERA_TX;
      end
      ESPERA_TX: begin
        // A byte arriving together with tx_done is deliberately dropped.
        if (i_tx_done) state_next = ESPERA_A;
      end
      default: state_next = ESPERA_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_dato_A   <= '0;
      o_dato_B   <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
    end else begin
      if (ld_a)  o_dato_A  <= i_rx_data;
      if (ld_b)  o_dato_B  <= i_rx_data;
      if (ld_op) o_opcode  <= i_rx_data;
      if (ld_tx) o_tx_data <= i_resultado_alu;
      o_tx_start <= ld_tx;
    end
  end

  assign o_busy = (state == ENVIO) || (state == ESPERA_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// tb/tb_alu_uart_interface.sv - directed-vector bench for alu_uart_interface
module tb_alu_uart_interface;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] alu_res;
  logic [7:0] dato_a, dato_b, opcode, tx_data;
  logic       tx_start, busy;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int start_base;

  always #5 clk = ~clk;

  // ALU model: opcode 0x22 subtracts, anything else adds.
  assign alu_res = (opcode == 8'h22) ? dato_a - dato_b : dato_a + dato_b;

  alu_uart_interface #(.TIMEOUT_CYCLES(16)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_tx_done(tx_done),
    .i_resultado_alu(alu_res),
    .o_dato_A(dato_a),
    .o_dato_B(dato_b),
    .o_opcode(opcode),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_busy(busy)
  );

  always @(negedge clk) if (tx_start) n_start++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] tx);
    check({tag, "_a"}, dato_a, a);
    check({tag, "_b"}, dato_b, b);
    check({tag, "_op"}, opcode, op);
    check({tag, "_tx"}, tx_data, tx);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    check("rst_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Basic add transaction and tx_start latency
    start_base = n_start;
    send(8'h05);
    send(8'h03);
    send(8'h20);
    check("t1_envio_start", tx_start, 1'b0);
    check("t1_envio_busy", busy, 1'b1);
    @(negedge clk);
    check("t1_start", tx_start, 1'b1);
    check_regs("t1", 8'h05, 8'h03, 8'h20, 8'h08);
    @(negedge clk);
    check("t1_start_end", tx_start, 1'b0);
    check("t1_busy_txw", busy, 1'b1);
    check("t1_pulses", n_start - start_base, 1);

    // Byte during ESPERA_TX is dropped; simultaneous tx_done+rx_done drops too
    send(8'h11);
    check_regs("t2_drop", 8'h05, 8'h03, 8'h20, 8'h08);
    @(negedge clk);
    rx_data = 8'h33; rx_done = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; tx_done = 1'b0;
    check("t2_busy_after", busy, 1'b0);
    check_regs("t2_sim", 8'h05, 8'h03, 8'h20, 8'h08);
    start_base = n_start;
    send(8'h0A);
    check("t2_a_loaded", dato_a, 8'h0A);
    send(8'h02);
    send(8'h22);
    repeat (2) @(negedge clk);
    check_regs("t2", 8'h0A, 8'h02, 8'h22, 8'h08);
    check("t2_pulses", n_start - start_base, 1);
    pulse_tx_done();

    // tx_done ignored in ESPERA_A and ESPERA_B
    start_base = n_start;
    pulse_tx_done();
    check("t3_busy_a", busy, 1'b0);
    send(8'h40);
    pulse_tx_done();
    check("t3_busy_b", busy, 1'b0);
    send(8'h01);
    check("t3_b_loaded", dato_b, 8'h01);
    send(8'h20);
    repeat (2) @(negedge clk);
    check_regs("t3", 8'h40, 8'h01, 8'h20, 8'h41);
    check("t3_pulses", n_start - start_base, 1);
    pulse_tx_done();

    // Asynchronous reset mid-sequence, then 8-bit wrap
    send(8'h12);
    send(8'h34);
    #3 rst_n = 1'b0;
    #1;
    check_regs("t4_async", 8'h00, 8'h00, 8'h00, 8'h00);
    check("t4_async_busy", busy, 1'b0);
    check("t4_async_start", tx_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    start_base = n_start;
    send(8'hFF);
    check("t4_a_first", dato_a, 8'hFF);
    send(8'h01);
    send(8'h20);
    repeat (2) @(negedge clk);
    check_regs("t4", 8'hFF, 8'h01, 8'h20, 8'h00);
    check("t4_pulses", n_start - start_base, 1);
    pulse_tx_done();

    // Inter-byte gap of 16 clocks
    start_base = n_start;
    send(8'h05);
    repeat (16) @(negedge clk);
    send(8'h07);
    send(8'h09);
    send(8'h20);
    repeat (3) @(negedge clk);
`ifdef ALU_UART_INTERFACE_TIMEOUT_EN
    check_regs("t5", 8'h07, 8'h09, 8'h20, 8'h10);
`else
    check_regs("t5", 8'h05, 8'h07, 8'h09, 8'h0C);
`endif
    check("t5_pulses", n_start - start_base, 1);
    check("t5_busy", busy, 1'b1);
    pulse_tx_done();
    check("t5_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 SHALL have parameter WIDTH_WORD, default 8: UART byte width.
REQ-002 SHALL have parameter BUS_DATOS_ALU, default 8: operand width; equals WIDTH_WORD.
REQ-003 SHALL have parameter BUS_SALIDA_ALU, default 8: ALU result width; equals WIDTH_WORD.
REQ-004 SHALL have parameter CANT_BIT_OPCODE, default 8: opcode width; equals WIDTH_WORD.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 10416000: inter-byte timeout in clocks, used only with the timeout feature.
REQ-006 SHALL have port i_clock  input  1  single system clock, rising edge.
REQ-007 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_rx_data  input  WIDTH_WORD  byte from UART receiver.
REQ-009 SHALL have port i_rx_done  input  1  one-cycle pulse, i_rx_data valid.
REQ-010 SHALL have port i_tx_done  input  1  one-cycle pulse, UART transmitter finished frame.
REQ-011 SHALL have port i_resultado_alu  input  BUS_SALIDA_ALU  combinational ALU result.
REQ-012 SHALL have port o_dato_A  output  BUS_DATOS_ALU  registered operand A.
REQ-013 SHALL have port o_dato_B  output  BUS_DATOS_ALU  registered operand B.
REQ-014 SHALL have port o_opcode  output  CANT_BIT_OPCODE  registered opcode.
REQ-015 SHALL have port o_tx_data  output  WIDTH_WORD  byte to UART transmitter.
REQ-016 SHALL have port o_tx_start  output  1  one-cycle pulse requesting transmission.
REQ-017 SHALL have port o_busy  output  1  high in states ENVIO and ESPERA_TX.

Function
REQ-018 SHALL implement FSM states ESPERA_A, ESPERA_B, ESPERA_OP, ENVIO, ESPERA_TX; all registered outputs change only on rising i_clock.
REQ-019 SHALL, in ESPERA_A with i_rx_done=1, load o_dato_A<=i_rx_data and go to ESPERA_B.
REQ-020 SHALL, in ESPERA_B with i_rx_done=1, load o_dato_B<=i_rx_data and go to ESPERA_OP.
REQ-021 SHALL, in ESPERA_OP with i_rx_done=1, load o_opcode<=i_rx_data and go to ENVIO.
REQ-022 SHALL, in ENVIO (unconditionally, one cycle), load o_tx_data<=i_resultado_alu, assert o_tx_start for exactly the following cycle, go to ESPERA_TX.
REQ-023 SHALL give latency: opcode rx_done edge N -> o_tx_start high during cycle N+2 with o_tx_data valid from the same cycle.
REQ-024 SHALL, in ESPERA_TX, stay until i_tx_done=1, then go to ESPERA_A.
REQ-025 SHALL ignore i_rx_done in ENVIO and ESPERA_TX (byte dropped, no register change).
REQ-026 SHALL, on simultaneous i_tx_done and i_rx_done in ESPERA_TX, go to ESPERA_A and drop the byte.
REQ-027 SHALL hold o_dato_A, o_dato_B, o_opcode, o_tx_data between loads; o_tx_data stays stable until next ENVIO.
REQ-028 SHALL ignore i_tx_done in all states except ESPERA_TX.

Reset
REQ-029 SHALL, while i_reset=0, force state ESPERA_A and o_dato_A, o_dato_B, o_opcode, o_tx_data to 0, o_tx_start and o_busy to 0, timeout counter to 0, independent of i_clock.
REQ-030 SHALL abort any in-progress sequence on reset; the first i_rx_done after release loads operand A.

Configuration
REQ-031 SHALL compile the inter-byte timeout only when macro ALU_UART_INTERFACE_TIMEOUT_EN is defined.
REQ-032 SHALL, with ALU_UART_INTERFACE_TIMEOUT_EN defined, count clocks in ESPERA_B and ESPERA_OP (cleared on every i_rx_done and state change) and, when the count reaches TIMEOUT_CYCLES-1 without i_rx_done, return to ESPERA_A keeping stored operands.
REQ-033 SHALL, without the macro, contain no timeout counter and wait indefinitely in ESPERA_B and ESPERA_OP.

Verification
REQ-034 SHALL test: bytes 0x05, 0x03, 0x20 with bench ALU model A+B -> o_dato_A=0x05, o_dato_B=0x03, o_opcode=0x20, single o_tx_start pulse 2 cycles after third rx_done, o_tx_data=0x08.
REQ-035 SHALL test: fourth byte 0x11 pulsed while in ESPERA_TX -> no register change; after i_tx_done the next three bytes 0x0A, 0x02, 0x22 (A-B model) yield o_tx_data=0x08.
REQ-036 SHALL test: i_reset=0 asserted between second and third byte -> all outputs 0 asynchronously; after release, bytes 0xFF, 0x01, 0x20 yield o_tx_data=0x00 (8-bit wrap).
REQ-037 SHALL test: i_tx_done pulsed in ESPERA_A and ESPERA_B -> no state change, no o_tx_start.
REQ-038 SHALL test with macro defined and TIMEOUT_CYCLES=16: send 0x05, wait 16 clocks, send 0x07, 0x09, 0x20 -> 0x07 taken as A, o_tx_data=0x10; without macro same stimulus -> o_tx_data=0x0C with o_opcode=0x09 ignored per model, and o_dato_B=0x07.
